// File: rtl/cla_adder_if.sv
// rtl/cla_adder_if.sv - operand/result bundle for the registered carry-lookahead adder
interface cla_adder_if #(
    parameter int WIDTH = 5
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output a,
        output b,
        input  sum,
        input  cout
    );

    modport slave (
        input  a,
        input  b,
        output sum,
        output cout
    );
endinterface

// File: rtl/cla_adder.sv
// rtl/cla_adder.sv - registered WIDTH-bit carry-lookahead adder, carry-in fixed at 0
module cla_adder #(
    parameter int WIDTH = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    cla_adder_if.slave   bus
);

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;
    logic             term;

    assign g = bus.a & bus.b;
    assign p = bus.a ^ bus.b;

    // Every carry is built directly from g/p products; no carry feeds another carry.
    always_comb begin
        c    = '0;
        term = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int k = j + 1; k <= i; k++) begin
                    term = term & p[k];
                end
                c[i+1] = c[i+1] | term;
            end
        end
    end

    assign s = p ^ c[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.sum  <= '0;
            bus.cout <= 1'b0;
        end else begin
            bus.sum  <= s;
            bus.cout <= c[WIDTH];
        end
    end

endmodule

// File: tb/tb_cla_adder.sv
// tb/tb_cla_adder.sv - randomized and exhaustive self-checking bench for cla_adder
module tb_cla_adder;

    localparam int W = 5;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    logic [W:0] prev = '0;

    always #5 clk = ~clk;

    cla_adder_if #(.WIDTH(W)) bus ();

    cla_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [W:0] got, input logic [W:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got {cout,sum}=%b expected %b", tag, got, exp);
        end
    endtask

    // Drive one operand pair (called just after a falling edge) and check it one rising edge later.
    // With glitch set, inputs and rst_n wiggle first and the held result must not move.
    task automatic step(input logic rn, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input bit glitch, input string tag);
        logic [W:0] exp;
        if (glitch) begin
            rst_n = 1'b0;
            bus.a = W'($urandom);
            bus.b = W'($urandom);
            #2;
            check({tag, "_hold"}, {bus.cout, bus.sum}, prev);
        end
        rst_n = rn;
        bus.a = av;
        bus.b = bv;
        exp   = rn ? ({1'b0, av} + {1'b0, bv}) : '0;
        @(negedge clk);
        check(tag, {bus.cout, bus.sum}, exp);
        prev = exp;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.a = '0;
        bus.b = '0;

        step(1'b0, 5'b10101, 5'b01011, 1'b0, "reset0");
        step(1'b0, 5'b10101, 5'b01011, 1'b0, "reset1");
        step(1'b1, 5'b10101, 5'b01011, 1'b0, "release");

        step(1'b1, 5'b00000, 5'b00000, 1'b0, "zero");
        step(1'b1, 5'b00101, 5'b00011, 1'b0, "add5_3");
        step(1'b1, 5'b01111, 5'b00001, 1'b0, "chain");
        step(1'b1, 5'b11111, 5'b00001, 1'b0, "wrap31_1");
        step(1'b1, 5'b10101, 5'b01011, 1'b0, "wrap21_11");
        step(1'b1, 5'b11111, 5'b11111, 1'b0, "wrap31_31");

        for (int i = 0; i < 40; i++) begin
            step((i != 20), W'($urandom), W'($urandom), (i % 3 == 0), "rand");
        end

        for (int x = 0; x < (1 << W); x++) begin
            for (int y = 0; y < (1 << W); y++) begin
                step(1'b1, W'(x), W'(y), 1'b0, "exh");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
